// File: rtl/spi_rom_read_arbiter_if.sv
// Requester-side bus of the SPI ROM read arbiter: two read request ports
// and the shared, ID-tagged returned byte stream.
interface spi_rom_read_arbiter_if;
    logic        req0;
    logic [23:0] addr0;
    logic [7:0]  len0;
    logic        gnt0;
    logic        req1;
    logic [23:0] addr1;
    logic [7:0]  len1;
    logic        gnt1;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        rd_id;
    logic        rd_last;

    modport master (
        output req0, addr0, len0, req1, addr1, len1,
        input  gnt0, gnt1, rd_data, rd_valid, rd_id, rd_last
    );

    modport slave (
        input  req0, addr0, len0, req1, addr1, len1,
        output gnt0, gnt1, rd_data, rd_valid, rd_id, rd_last
    );
endinterface

// File: rtl/spi_rom_read_arbiter.sv
// Two-requester arbiter for one SPI flash: runs READ (03h) transactions with
// a registered clk/2 SCLK and returns the data bytes tagged with the owner ID.
module spi_rom_read_arbiter #(
    parameter logic [7:0] READ_CMD        = 8'h03,
    parameter int         DESELECT_CYCLES = 2,
    parameter int         STARVE_LIMIT    = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    spi_rom_read_arbiter_if.slave        bus,
    output logic                         busy,
    output logic                         spi_cs,
    output logic                         spi_sclk,
    output logic                         spi_mosi,
    input  logic                         spi_miso
);
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_CMD   = 3'd2,
        ST_ADDR  = 3'd3,
        ST_DATA  = 3'd4,
        ST_GAP   = 3'd5
    } state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [3:0] GAP_LOAD   = 4'(DESELECT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        phase_q, phase_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [8:0]  bytes_left_q, bytes_left_d;
    logic [31:0] tx_q, tx_d;
    logic [7:0]  rx_q, rx_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic [3:0]  starve_q, starve_d;
    logic        gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic        rd_valid_q, rd_valid_d, rd_last_q, rd_last_d, rd_id_q, rd_id_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        busy_q, busy_d, spi_cs_q, spi_cs_d;
    logic        spi_sclk_q, spi_sclk_d, spi_mosi_q, spi_mosi_d;
    logic        grant0_s, grant1_s, shifting_s;

    // Next-state, arbitration and serial-sequencing logic
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        bit_cnt_d    = bit_cnt_q;
        bytes_left_d = bytes_left_q;
        tx_d         = tx_q;
        rx_d         = rx_q;
        gap_cnt_d    = gap_cnt_q;
        starve_d     = starve_q;
        gnt0_d       = 1'b0;
        gnt1_d       = 1'b0;
        rd_valid_d   = 1'b0;
        rd_last_d    = 1'b0;
        rd_id_d      = rd_id_q;
        rd_data_d    = rd_data_q;
        grant0_s     = 1'b0;
        grant1_s     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                grant1_s = bus.req1 && ((starve_q == STARVE_MAX) || !bus.req0);
                grant0_s = bus.req0 && !grant1_s;
                if (grant1_s) begin
                    gnt1_d   = 1'b1;
                    rd_id_d  = 1'b1;
                    starve_d = 4'd0;
                    state_d  = ST_GRANT;
                end else if (grant0_s) begin
                    gnt0_d  = 1'b1;
                    rd_id_d = 1'b0;
                    state_d = ST_GRANT;
                    if (!bus.req1) begin
                        starve_d = 4'd0;
                    end else if (starve_q != STARVE_MAX) begin
                        starve_d = starve_q + 4'd1;
                    end else begin
                        starve_d = starve_q;
                    end
                end else begin
                    starve_d = bus.req1 ? starve_q : 4'd0;
                end
            end
            ST_GRANT: begin
                // The owner's address and length are held valid through the grant cycle.
                tx_d         = rd_id_q ? {READ_CMD, bus.addr1} : {READ_CMD, bus.addr0};
                bytes_left_d = rd_id_q ? ({1'b0, bus.len1} + 9'd1) : ({1'b0, bus.len0} + 9'd1);
                bit_cnt_d    = 5'd7;
                phase_d      = 1'b0;
                state_d      = ST_CMD;
            end
            ST_CMD, ST_ADDR, ST_DATA: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                    rx_d    = (state_q == ST_DATA) ? {rx_q[6:0], spi_miso} : rx_q;
                end else begin
                    phase_d = 1'b0;
                    tx_d    = {tx_q[30:0], 1'b0};
                    if (bit_cnt_q != 5'd0) begin
                        bit_cnt_d = bit_cnt_q - 5'd1;
                    end else if (state_q == ST_CMD) begin
                        bit_cnt_d = 5'd23;
                        state_d   = ST_ADDR;
                    end else if (state_q == ST_ADDR) begin
                        bit_cnt_d = 5'd7;
                        state_d   = ST_DATA;
                    end else begin
                        bit_cnt_d  = 5'd7;
                        rd_valid_d = 1'b1;
                        rd_data_d  = rx_q;
                        rd_last_d  = (bytes_left_q == 9'd1);
                        if (bytes_left_q == 9'd1) begin
                            state_d   = ST_GAP;
                            gap_cnt_d = GAP_LOAD;
                        end else begin
                            bytes_left_d = bytes_left_q - 9'd1;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Pin values are derived from the next state so they leave the flops glitch-free.
        shifting_s = (state_d == ST_CMD) || (state_d == ST_ADDR) || (state_d == ST_DATA);
        spi_cs_d   = shifting_s;
        spi_sclk_d = shifting_s && phase_d;
        spi_mosi_d = ((state_d == ST_CMD) || (state_d == ST_ADDR)) ? tx_d[31] : 1'b0;
        busy_d     = (state_d != ST_IDLE);
    end

    // State and registered-output flops with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            phase_q      <= 1'b0;
            bit_cnt_q    <= 5'd0;
            bytes_left_q <= 9'd0;
            tx_q         <= 32'd0;
            rx_q         <= 8'd0;
            gap_cnt_q    <= 4'd0;
            starve_q     <= 4'd0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_last_q    <= 1'b0;
            rd_id_q      <= 1'b0;
            rd_data_q    <= 8'd0;
            busy_q       <= 1'b0;
            spi_cs_q     <= 1'b0;
            spi_sclk_q   <= 1'b0;
            spi_mosi_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            bit_cnt_q    <= bit_cnt_d;
            bytes_left_q <= bytes_left_d;
            tx_q         <= tx_d;
            rx_q         <= rx_d;
            gap_cnt_q    <= gap_cnt_d;
            starve_q     <= starve_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            rd_valid_q   <= rd_valid_d;
            rd_last_q    <= rd_last_d;
            rd_id_q      <= rd_id_d;
            rd_data_q    <= rd_data_d;
            busy_q       <= busy_d;
            spi_cs_q     <= spi_cs_d;
            spi_sclk_q   <= spi_sclk_d;
            spi_mosi_q   <= spi_mosi_d;
        end
    end

    assign bus.gnt0     = gnt0_q;
    assign bus.gnt1     = gnt1_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_id    = rd_id_q;
    assign bus.rd_last  = rd_last_q;
    assign busy         = busy_q;
    assign spi_cs       = spi_cs_q;
    assign spi_sclk     = spi_sclk_q;
    assign spi_mosi     = spi_mosi_q;
endmodule

// File: doc/spi_rom_read_arbiter.md
Name: spi_rom_read_arbiter

Overview:
- Shares one SPI flash ROM between two read requesters: requester 0 is the video line prefetch and has priority; requester 1 is a secondary/debug reader.
- Sequences complete READ (03h) transactions: CMD byte, 24-bit address, then N data bytes returned as a byte stream tagged with the requester ID.
- Generates its own SCLK at clk/2, so MISO/MOSI timing is registered and free of clock gating.
- Sits between the video/fetch logic and the top-level SPI pins.

Parameters:
- READ_CMD, 8'h03, command byte sent MSB-first.
- DESELECT_CYCLES, 2, minimum clk cycles spi_cs stays low between transactions (range 1..15).
- STARVE_LIMIT, 4, consecutive req0 grants allowed while req1 waits before req1 is forced in (range 1..15).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 request; held until gnt0.
- addr0  in  24  requester 0 start byte address.
- len0  in  8  requester 0 length; byte count = len0+1 (1..256).
- gnt0  out  1  one-cycle grant pulse; addr0/len0 captured this cycle.
- req1  in  1  requester 1 request; held until gnt1.
- addr1  in  24  requester 1 start byte address.
- len1  in  8  requester 1 length; byte count = len1+1.
- gnt1  out  1  one-cycle grant pulse.
- rd_data  out  8  received byte, MSB first on wire.
- rd_valid  out  1  one-cycle strobe; rd_data, rd_id, rd_last valid.
- rd_id  out  1  requester owning the current transaction.
- rd_last  out  1  high with rd_valid on the final byte.
- busy  out  1  high in every state except IDLE.
- spi_cs  out  1  chip select, ACTIVE HIGH; parent inverts.
- spi_sclk  out  1  registered SPI clock, mode 0, idles low.
- spi_mosi  out  1  registered serial out.
- spi_miso  in  1  serial in.

Behaviour:
- Reset (sync): state=IDLE; spi_cs=0, spi_sclk=0, spi_mosi=0, gnt0=gnt1=0, rd_valid=0, rd_last=0, rd_id=0, rd_data=0, starve counter=0.
- States: IDLE -> CMD (8 bits) -> ADDR (24 bits) -> DATA (8*(len+1) bits) -> GAP (DESELECT_CYCLES) -> IDLE.
- IDLE arbitration, evaluated each cycle:
  - If req1 && starve==STARVE_LIMIT: grant 1.
  - Else if req0: grant 0.
  - Else if req1: grant 1.
  - Else stay in IDLE.
- Grant cycle: gntX=1 for exactly one cycle; addr/len latched; rd_id=X; next state CMD.
- Starve counter: increments on a gnt0 issued while req1 is high; clears on gnt1 or when req1 is low in IDLE; saturates at STARVE_LIMIT.
- Bit period = 2 clk cycles.
  - Phase A: spi_sclk=0, spi_mosi holds the current bit.
  - Phase B: spi_sclk=1.
  - spi_cs=1 from the first phase A of CMD bit 7 through the last phase B of the final data bit.
  - MISO is sampled into the shift register on the clk edge that drives spi_sclk high (end of phase A).
- MOSI: READ_CMD[7:0], then addr[23:0], MSB-first; 0 during DATA.
- Bytes: after each 8th DATA sample, rd_data is loaded and rd_valid pulses on the next cycle. rd_last=1 with the (len+1)th byte. No backpressure: consumers must accept every strobe.
- After the final bit, the next cycle enters GAP with spi_cs=0 and spi_sclk=0. GAP lasts exactly DESELECT_CYCLES cycles, then IDLE. A request is never granted before GAP completes.
- Transaction length, grant cycle to IDLE: 1 + 2*(32 + 8*(len+1)) + DESELECT_CYCLES clk cycles.
- Requests arriving while busy wait; no grant is issued and no queueing occurs beyond the held req line.
- Simultaneous req0 and req1 with starve<STARVE_LIMIT: req0 wins.
- len=8'hFF: 256 bytes; the internal byte counter is 9 bits and must not wrap early.
- Reset mid-transaction: the next edge forces spi_cs=0 and spi_sclk=0. rd_valid must not pulse during or after reset for the aborted transfer, and no GAP is inserted.
- Address ordering and wrap-around within the flash are the flash's concern; the block only sends the 24-bit start address.

Test Plan:
- req0, addr0=24'h000123, len0=0, flash byte=8'hA5:
  - MOSI bits = 03 00 01 23.
  - spi_cs high for exactly 80 cycles; 40 SCLK rising edges.
  - One rd_valid with rd_data=A5, rd_id=0, rd_last=1.
  - busy for 1+80+2=83 cycles.
- req0 and req1 asserted in the same cycle, len=3 each: gnt0 first with 4 bytes tagged id 0; then gnt1 only after spi_cs has been low ≥2 cycles, with 4 bytes tagged id 1.
- STARVE_LIMIT=2, req0 and req1 held continuously: grant order 0,0,1,0,0,1.
- len1=8'hFF from an incrementing-pattern flash model: 256 rd_valid strobes with data 00..FF; rd_last only on the 256th.
- reset asserted mid-DATA after byte 2 of 8: spi_cs=0 and spi_sclk=0 on the next cycle; no further rd_valid. A fresh req0 then completes normally.
- Idle with no requests for 100 cycles: spi_cs=0, spi_sclk=0, spi_mosi=0, no grants.
